irq_redirect_ctrl: RTL and testbench

//  Parametrised interrupt/debug redirect controller sitting between the control and datapath of the sodor cores.

---
 rtl/irq_redirect_ctrl_if.sv | 49 ++++
 rtl/irq_redirect_ctrl.sv | 155 +++++++++++++++
 tb/tb_irq_redirect_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/irq_redirect_ctrl_if.sv
// ============================================================================
// Module   : irq_redirect_ctrl_if
// Brief    : Bundle of interrupt, debug and pc_sel signals between the core
//            control path and the interrupt/debug redirect controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface irq_redirect_ctrl_if #(
  parameter int NUM_IRQ  = 4,
  parameter int PC_SEL_W = 3,
  parameter int CNT_W    = 16
);
  logic [NUM_IRQ-1:0]  io_irq;
  logic [NUM_IRQ-1:0]  io_irq_mask;
  logic                io_global_ie;
  logic                io_interrupt_debug;
  logic                io_debug_resume;
  logic                io_inst_valid;
  logic                io_ctl_exception;
  logic                io_mret;
  logic [PC_SEL_W-1:0] io_pc_sel_in;
  logic [PC_SEL_W-1:0] io_pc_sel_out;
  logic                io_csr_interrupt;
  logic [4:0]          io_irq_cause;
  logic                io_irq_taken;
  logic                io_debug_halted;
  logic [CNT_W-1:0]    io_taken_count;

  // Core side: drives requests and control-path state, observes the redirect.
  modport master (
    output io_irq, io_irq_mask, io_global_ie, io_interrupt_debug,
           io_debug_resume, io_inst_valid, io_ctl_exception, io_mret,
           io_pc_sel_in,
    input  io_pc_sel_out, io_csr_interrupt, io_irq_cause, io_irq_taken,
           io_debug_halted, io_taken_count
  );

  // Controller side.
  modport slave (
    input  io_irq, io_irq_mask, io_global_ie, io_interrupt_debug,
           io_debug_resume, io_inst_valid, io_ctl_exception, io_mret,
           io_pc_sel_in,
    output io_pc_sel_out, io_csr_interrupt, io_irq_cause, io_irq_taken,
           io_debug_halted, io_taken_count
  );
endinterface

`default_nettype wire

// File: rtl/irq_redirect_ctrl.sv
// ============================================================================
// Module   : irq_redirect_ctrl
// Brief    : Interrupt/debug redirect controller. Arbitrates masked sources
//            (lowest index wins), raises csr_interrupt, overrides pc_sel with
//            the trap select for exactly one cycle at an instruction
//            boundary, supports a debug halt and counts redirects.
//            Optional feature macro: IRQ_EDGE_EN (sticky edge-triggered
//            pending bits instead of level-sensitive sources).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_redirect_ctrl #(
  parameter int NUM_IRQ    = 4,
  parameter int PC_SEL_W   = 3,
  parameter int PC_SEL_EXC = 4,
  parameter int CNT_W      = 16
) (
  input  wire logic           clock,
  input  wire logic           reset,
  irq_redirect_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HANDLER = 2'd2,
    ST_DEBUG   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               ret_hdl_q, ret_hdl_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [4:0]         cause_q;
  logic [CNT_W-1:0]   count_q;

  logic [NUM_IRQ-1:0] pend;
  logic               pend_any;
  logic [4:0]         win_idx;
  logic               redirect;

  // Register raw sources once before arbitration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) irq_q <= '0;
    else       irq_q <= bus.io_irq;
  end

`ifdef IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pend_r_q, pend_r_d;
  logic [NUM_IRQ-1:0] claim_clr;

  // The claimed bit drops on redirect; a fresh rising edge in the same cycle
  // wins so that edge is not lost.
  assign claim_clr = redirect ? (NUM_IRQ'(1) << win_idx) : '0;
  assign pend_r_d  = (pend_r_q & ~claim_clr) | (irq_q & ~irq_prev_q);

  // Sticky pending bits set on each rising edge of the registered source.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_prev_q <= '0;
      pend_r_q   <= '0;
    end else begin
      irq_prev_q <= irq_q;
      pend_r_q   <= pend_r_d;
    end
  end

  assign pend = pend_r_q & bus.io_irq_mask;
`else
  assign pend = irq_q & bus.io_irq_mask;
`endif

  assign pend_any = |pend;

  // Lowest set index wins; scanning downward lets the lowest index land last.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) win_idx = 5'(i);
    end
  end

  // Next-state and redirect decision; debug request outranks everything.
  always_comb begin
    state_d   = state_q;
    ret_hdl_d = ret_hdl_q;
    redirect  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.io_interrupt_debug) begin
          state_d   = ST_DEBUG;
          ret_hdl_d = 1'b0;
        end else if (bus.io_global_ie && pend_any) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.io_interrupt_debug) begin
          state_d   = ST_DEBUG;
          ret_hdl_d = 1'b0;
        end else if (!pend_any) begin
          state_d = ST_IDLE;
        end else if (bus.io_ctl_exception) begin
          // Synchronous exception owns pc_sel this cycle; keep requesting.
          state_d = ST_REQ;
        end else if (bus.io_inst_valid) begin
          redirect = 1'b1;
          state_d  = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (bus.io_interrupt_debug) begin
          state_d   = ST_DEBUG;
          ret_hdl_d = 1'b1;
        end else if (bus.io_mret) begin
          state_d = ST_IDLE;
        end
      end
      ST_DEBUG: begin
        if (bus.io_debug_resume && !bus.io_interrupt_debug) begin
          state_d = ret_hdl_q ? ST_HANDLER : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, return flag, claimed cause and saturating redirect counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ret_hdl_q <= 1'b0;
      cause_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ret_hdl_q <= ret_hdl_d;
      if (redirect) begin
        cause_q <= win_idx;
        if (count_q != {CNT_W{1'b1}}) count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.io_pc_sel_out    = redirect ? PC_SEL_W'(PC_SEL_EXC) : bus.io_pc_sel_in;
  assign bus.io_irq_taken     = redirect;
  assign bus.io_csr_interrupt = (state_q == ST_REQ);
  assign bus.io_debug_halted  = (state_q == ST_DEBUG);
  assign bus.io_irq_cause     = cause_q;
  assign bus.io_taken_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_redirect_ctrl.sv
// ============================================================================
// Module   : tb_irq_redirect_ctrl
// Brief    : Self-checking bench for irq_redirect_ctrl. Two instances share
//            one stimulus stream: default counter width and a 2-bit counter
//            to exercise saturation. Outputs are compared each cycle against
//            a behavioural model of the controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_redirect_ctrl;

  localparam int N     = 4;
  localparam int PCW   = 3;
  localparam int EXC   = 4;
  localparam int CWA   = 16;
  localparam int CWB   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   t_irq, t_mask;
  logic           t_ie, t_dbg, t_res, t_valid, t_exc, t_mret;
  logic [PCW-1:0] t_pcin;

  irq_redirect_ctrl_if #(.NUM_IRQ(N), .PC_SEL_W(PCW), .CNT_W(CWA)) ifa ();
  irq_redirect_ctrl_if #(.NUM_IRQ(N), .PC_SEL_W(PCW), .CNT_W(CWB)) ifb ();

  assign ifa.io_irq = t_irq;              assign ifb.io_irq = t_irq;
  assign ifa.io_irq_mask = t_mask;        assign ifb.io_irq_mask = t_mask;
  assign ifa.io_global_ie = t_ie;         assign ifb.io_global_ie = t_ie;
  assign ifa.io_interrupt_debug = t_dbg;  assign ifb.io_interrupt_debug = t_dbg;
  assign ifa.io_debug_resume = t_res;     assign ifb.io_debug_resume = t_res;
  assign ifa.io_inst_valid = t_valid;     assign ifb.io_inst_valid = t_valid;
  assign ifa.io_ctl_exception = t_exc;    assign ifb.io_ctl_exception = t_exc;
  assign ifa.io_mret = t_mret;            assign ifb.io_mret = t_mret;
  assign ifa.io_pc_sel_in = t_pcin;       assign ifb.io_pc_sel_in = t_pcin;

  irq_redirect_ctrl #(.NUM_IRQ(N), .PC_SEL_W(PCW), .PC_SEL_EXC(EXC), .CNT_W(CWA))
    dut_a (.clock(clk), .reset(rst), .bus(ifa));
  irq_redirect_ctrl #(.NUM_IRQ(N), .PC_SEL_W(PCW), .PC_SEL_EXC(EXC), .CNT_W(CWB))
    dut_b (.clock(clk), .reset(rst), .bus(ifb));

  int n_vec = 0;
  int n_bad = 0;

  // Model: operating mode as plain integers, plus counters kept unbounded.
  localparam int M_IDLE = 0, M_WAIT = 1, M_HANDLER = 2, M_HALT = 3;
  int       m_mode;
  bit       m_back_to_handler;
  bit [N-1:0] m_seen, m_seen_prev, m_sticky;
  int       m_cause;
  int       m_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_back_to_handler = 0;
    m_seen = '0; m_seen_prev = '0; m_sticky = '0;
    m_cause = 0; m_total = 0;
  endtask

  // One clock: check outputs at negedge, then advance the model at posedge.
  task automatic step();
    bit [N-1:0] pend;
    int  win;
    bit  take;
    int  nxt;
`ifdef IRQ_EDGE_EN
    pend = m_sticky & t_mask;
`else
    pend = m_seen & t_mask;
`endif
    win = 0;
    for (int i = 0; i < N; i++) if (pend[i]) begin win = i; break; end
    take = !rst && m_mode == M_WAIT && !t_dbg && pend != 0 && !t_exc && t_valid;

    @(negedge clk);
    chk("pc_sel_out",    32'(ifa.io_pc_sel_out),    take ? 32'(EXC) : 32'(t_pcin));
    chk("irq_taken",     32'(ifa.io_irq_taken),     32'(take));
    chk("csr_interrupt", 32'(ifa.io_csr_interrupt), 32'(m_mode == M_WAIT));
    chk("debug_halted",  32'(ifa.io_debug_halted),  32'(m_mode == M_HALT));
    chk("irq_cause",     32'(ifa.io_irq_cause),     32'(m_cause));
    chk("count16",       32'(ifa.io_taken_count),   32'(m_total > 65535 ? 65535 : m_total));
    chk("count2",        32'(ifb.io_taken_count),   32'(m_total > 3 ? 3 : m_total));
    chk("b_pc_sel_out",  32'(ifb.io_pc_sel_out),    take ? 32'(EXC) : 32'(t_pcin));

    @(posedge clk);
    if (!rst) begin
      nxt = m_mode;
      case (m_mode)
        M_IDLE:    if (t_dbg) begin nxt = M_HALT; m_back_to_handler = 0; end
                   else if (t_ie && pend != 0) nxt = M_WAIT;
        M_WAIT:    if (t_dbg) begin nxt = M_HALT; m_back_to_handler = 0; end
                   else if (pend == 0) nxt = M_IDLE;
                   else if (take) begin nxt = M_HANDLER; m_cause = win; m_total++; end
        M_HANDLER: if (t_dbg) begin nxt = M_HALT; m_back_to_handler = 1; end
                   else if (t_mret) nxt = M_IDLE;
        default:   if (t_res && !t_dbg) nxt = m_back_to_handler ? M_HANDLER : M_IDLE;
      endcase
      m_mode = nxt;
      for (int i = 0; i < N; i++) begin
        if (take && i == win) m_sticky[i] = 1'b0;
        if (m_seen[i] && !m_seen_prev[i]) m_sticky[i] = 1'b1;
      end
      m_seen_prev = m_seen;
      m_seen = t_irq;
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b1;
    t_irq = '0; t_mask = '0; t_ie = 0; t_dbg = 0; t_res = 0;
    t_valid = 0; t_exc = 0; t_mret = 0; t_pcin = 3'd2;
    model_reset();
    #1;
    steps(2);
    rst = 1'b0;
    steps(2);

    // Basic redirect: sources 1 and 2 pending, lowest (1) claimed.
    t_mask = 4'b1111; t_ie = 1; t_irq = 4'b0110; t_valid = 1; t_pcin = 3'd1;
    steps(5);

    // Exception holds off the redirect for three cycles.
    t_mret = 1; step(); t_mret = 0;
    t_exc = 1; step(); steps(3);
    t_exc = 0; steps(2);

    // Handler masks a held source until mret.
    t_irq = 4'b0001; steps(4);
    t_mret = 1; step(); t_mret = 0; t_valid = 0; steps(2);
    t_valid = 1; steps(2);

    // Debug inside the handler, resume after debug drops, mret afterwards.
    t_dbg = 1; steps(3);
    t_res = 1; step(); t_res = 0;
    t_dbg = 0; steps(2);
    t_res = 1; step(); t_res = 0; steps(2);
    t_mret = 1; step(); t_mret = 0;

    // Several redirects to saturate the narrow counter.
    for (int j = 0; j < 5; j++) begin
      steps(3);
      t_mret = 1; step(); t_mret = 0;
    end
    steps(3);

    // Reset while requesting.
    t_mret = 1; t_valid = 0; step(); t_mret = 0; steps(2);
    rst = 1'b1; model_reset(); steps(2);
    rst = 1'b0; steps(2);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      t_irq   = 4'($urandom);
      t_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      t_ie    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 29) == 0) t_dbg = ~t_dbg;
      t_res   = ($urandom_range(0, 5) == 0);
      t_valid = ($urandom_range(0, 9) < 6);
      t_exc   = ($urandom_range(0, 3) == 0);
      t_mret  = ($urandom_range(0, 4) == 0);
      t_pcin  = 3'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1; model_reset(); step(); rst = 1'b0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
